// File: rtl/load_use_scoreboard_if.sv
// Decode-to-hazard-unit bundle: ID-stage instruction fields in, stall/bubble controls and status out.
interface load_use_scoreboard_if #(
  parameter int NUM_REGS = 8,
  parameter int RW       = 3,
  parameter int NUM_SRC  = 2,
  parameter int PCW      = 16
);
  logic                   id_valid;
  logic [NUM_SRC*RW-1:0]  id_src;
  logic [NUM_SRC-1:0]     id_src_used;
  logic [RW-1:0]          id_dest;
  logic                   id_writes;
  logic                   id_is_load;
  logic                   mem_stall;
  logic                   flush;
  logic                   hazard;
  logic                   forward_load;
  logic [NUM_REGS-1:0]    pending;
  logic [PCW-1:0]         stall_cycles;

  modport master (
    output id_valid, id_src, id_src_used, id_dest, id_writes, id_is_load, mem_stall, flush,
    input  hazard, forward_load, pending, stall_cycles
  );

  modport slave (
    input  id_valid, id_src, id_src_used, id_dest, id_writes, id_is_load, mem_stall, flush,
    output hazard, forward_load, pending, stall_cycles
  );
endinterface

// File: rtl/load_use_scoreboard.sv
// Load-use hazard unit: per-register countdown until an in-flight load's data is forwardable,
// stalling the ID instruction while any used source is still counting down.
module load_use_scoreboard #(
  parameter int NUM_REGS = 8,
  parameter int RW       = 3,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 2,
  parameter int CW       = 2,
  parameter int PCW      = 16
) (
  input logic                clk,
  input logic                rst,
  load_use_scoreboard_if.slave bus
);

  logic [CW-1:0]       cnt_q [NUM_REGS];
  logic [CW-1:0]       cnt_d [NUM_REGS];
  logic [PCW-1:0]      stallCnt_q;
  logic [PCW-1:0]      stallCnt_d;
  logic                srcHit;
  logic                hazard;
  logic                issue;
  logic [NUM_REGS-1:0] pendingVec;

  // Sources compare against the pre-issue counts, so an instruction reading its own dest sees the old value.
  always_comb begin
    srcHit = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (bus.id_src_used[k] && (cnt_q[bus.id_src[k*RW +: RW]] != '0)) begin
        srcHit = 1'b1;
      end
    end
  end

  assign hazard = bus.id_valid && !bus.flush && srcHit;
  assign issue  = bus.id_valid && !hazard && !bus.flush && !bus.mem_stall;

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (bus.flush) begin
        cnt_d[r] = '0;
      end else if (!bus.mem_stall) begin
        // A younger writer of the same register replaces any countdown still running there.
        if (issue && bus.id_writes && (bus.id_dest == RW'(r))) begin
          cnt_d[r] = bus.id_is_load ? CW'(LOAD_LAT) : '0;
        end else if (cnt_q[r] != '0) begin
          cnt_d[r] = cnt_q[r] - CW'(1);
        end
      end
    end
  end

  always_comb begin
    stallCnt_d = stallCnt_q;
    if (hazard && !bus.mem_stall && (stallCnt_q != '1)) begin
      stallCnt_d = stallCnt_q + PCW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
      stallCnt_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      stallCnt_q <= stallCnt_d;
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      pendingVec[r] = (cnt_q[r] != '0);
    end
  end

  assign bus.hazard       = hazard;
  assign bus.forward_load = !hazard;
  assign bus.pending      = pendingVec;
  assign bus.stall_cycles = stallCnt_q;

endmodule

// File: tb/tb_load_use_scoreboard.sv
// Directed bench for load_use_scoreboard: lc3b-style load/consumer sequences with hand-computed
// expectations, plus a narrow-counter instance for stall_cycles saturation.
module tb_load_use_scoreboard;

  logic clk;
  logic rst;
  int   compareCount;
  int   failCount;

  load_use_scoreboard_if #(.PCW(16)) bus ();
  load_use_scoreboard_if #(.PCW(4))  satBus ();

  load_use_scoreboard #(.LOAD_LAT(2), .PCW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  load_use_scoreboard #(.LOAD_LAT(2), .PCW(4)) satDut (
    .clk (clk),
    .rst (rst),
    .bus (satBus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [2:0] src0, input logic [2:0] src1,
                               input logic [1:0] used, input logic [2:0] dest, input logic writes,
                               input logic isLoad, input logic memStall, input logic flushIn);
    bus.id_valid    = valid;
    bus.id_src      = {src1, src0};
    bus.id_src_used = used;
    bus.id_dest     = dest;
    bus.id_writes   = writes;
    bus.id_is_load  = isLoad;
    bus.mem_stall   = memStall;
    bus.flush       = flushIn;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    compareCount = 0;
    failCount    = 0;
    rst          = 1'b1;
    satBus.id_valid    = 1'b0;
    satBus.id_src      = '0;
    satBus.id_src_used = '0;
    satBus.id_dest     = '0;
    satBus.id_writes   = 1'b0;
    satBus.id_is_load  = 1'b0;
    satBus.mem_stall   = 1'b0;
    satBus.flush       = 1'b0;
    applyStimulus(1'b0, 3'd0, 3'd0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state
    checkOutput("rst_hazard", 32'(bus.hazard), 32'd0);
    checkOutput("rst_fwd", 32'(bus.forward_load), 32'd1);
    checkOutput("rst_pending", 32'(bus.pending), 32'h00);
    checkOutput("rst_stall", 32'(bus.stall_cycles), 32'd0);
    tick();
    rst = 1'b0;
    #1;

    // Back-to-back: LDR R3, then ADD R1,R3,R2 stalls two cycles
    applyStimulus(1'b1, 3'd0, 3'd0, 2'b01, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("b2b_ldr_hazard", 32'(bus.hazard), 32'd0);
    tick();
    applyStimulus(1'b1, 3'd3, 3'd2, 2'b11, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("b2b_hazard_c1", 32'(bus.hazard), 32'd1);
    checkOutput("b2b_fwd_c1", 32'(bus.forward_load), 32'd0);
    checkOutput("b2b_pending_c1", 32'(bus.pending), 32'h08);
    tick();
    checkOutput("b2b_hazard_c2", 32'(bus.hazard), 32'd1);
    tick();
    checkOutput("b2b_hazard_c3", 32'(bus.hazard), 32'd0);
    checkOutput("b2b_pending_c3", 32'(bus.pending), 32'h00);
    checkOutput("b2b_stall", 32'(bus.stall_cycles), 32'd2);
    tick();

    // Immediate form: src1 = R3 pending but unused
    applyStimulus(1'b1, 3'd0, 3'd0, 2'b01, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 3'd2, 3'd3, 2'b01, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("imm_pending", 32'(bus.pending), 32'h08);
    checkOutput("imm_hazard", 32'(bus.hazard), 32'd0);
    tick();
    applyStimulus(1'b0, 3'd3, 3'd3, 2'b11, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("bubble_hazard", 32'(bus.hazard), 32'd0);
    tick();
    checkOutput("imm_drained", 32'(bus.pending), 32'h00);

    // Memory back-pressure: consumer of R4 with three frozen cycles
    applyStimulus(1'b1, 3'd0, 3'd0, 2'b01, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 3'd4, 3'd0, 2'b01, 3'd6, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("ms_hazard_frozen%0d", i), 32'(bus.hazard), 32'd1);
      checkOutput($sformatf("ms_pending_frozen%0d", i), 32'(bus.pending), 32'h10);
      tick();
    end
    checkOutput("ms_stall_after_freeze", 32'(bus.stall_cycles), 32'd2);
    applyStimulus(1'b1, 3'd4, 3'd0, 2'b01, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("ms_hazard_c4", 32'(bus.hazard), 32'd1);
    tick();
    checkOutput("ms_hazard_c5", 32'(bus.hazard), 32'd1);
    checkOutput("ms_stall_c5", 32'(bus.stall_cycles), 32'd3);
    tick();
    checkOutput("ms_hazard_c6", 32'(bus.hazard), 32'd0);
    checkOutput("ms_stall_end", 32'(bus.stall_cycles), 32'd4);
    checkOutput("ms_pending_end", 32'(bus.pending), 32'h00);
    tick();

    // WAW: LDR R5 then ADD R5,R1,R2 cancels the countdown
    applyStimulus(1'b1, 3'd0, 3'd0, 2'b01, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 3'd1, 3'd2, 2'b11, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("waw_add_hazard", 32'(bus.hazard), 32'd0);
    checkOutput("waw_pending_before", 32'(bus.pending), 32'h20);
    tick();
    applyStimulus(1'b1, 3'd5, 3'd0, 2'b01, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("waw_pending_after", 32'(bus.pending), 32'h00);
    checkOutput("waw_consumer_hazard", 32'(bus.hazard), 32'd0);
    tick();

    // Flush with loads to R1/R2/R3 issued back to back
    applyStimulus(1'b1, 3'd0, 3'd0, 2'b01, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 3'd0, 3'd0, 2'b01, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 3'd0, 3'd0, 2'b01, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 3'd2, 3'd3, 2'b11, 3'd6, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("flush_pending_before", 32'(bus.pending), 32'h0C);
    checkOutput("flush_hazard", 32'(bus.hazard), 32'd0);
    checkOutput("flush_fwd", 32'(bus.forward_load), 32'd1);
    tick();
    applyStimulus(1'b1, 3'd2, 3'd3, 2'b11, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("flush_pending_after", 32'(bus.pending), 32'h00);
    checkOutput("flush_hazard_after", 32'(bus.hazard), 32'd0);
    checkOutput("flush_stall", 32'(bus.stall_cycles), 32'd4);
    tick();

    // Reset asserted mid-stall
    applyStimulus(1'b1, 3'd0, 3'd0, 2'b01, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 3'd3, 3'd0, 2'b01, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("rstmid_hazard_before", 32'(bus.hazard), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rstmid_hazard", 32'(bus.hazard), 32'd0);
    checkOutput("rstmid_pending", 32'(bus.pending), 32'h00);
    checkOutput("rstmid_stall", 32'(bus.stall_cycles), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("rstrel_hazard", 32'(bus.hazard), 32'd0);
    checkOutput("rstrel_pending", 32'(bus.pending), 32'h00);
    tick();

    // Saturation on a 4-bit counter: LDR R3,R3 held in ID gives two hazard cycles every three
    applyStimulus(1'b0, 3'd0, 3'd0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    satBus.id_valid    = 1'b1;
    satBus.id_src      = {3'd0, 3'd3};
    satBus.id_src_used = 2'b01;
    satBus.id_dest     = 3'd3;
    satBus.id_writes   = 1'b1;
    satBus.id_is_load  = 1'b1;
    #1;
    for (int i = 0; i < 21; i++) tick();
    checkOutput("sat_stall_14", 32'(satBus.stall_cycles), 32'd14);
    for (int i = 0; i < 9; i++) tick();
    checkOutput("sat_stall_15", 32'(satBus.stall_cycles), 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
